// File: rtl/ram_uart_dump_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ram_uart_dump_ctrl
// Brief    : Streams a block of RAM bytes out through a UART transmitter,
//            one byte per trigger/busy handshake, with an ack timeout.
// Revision : 1.0 - initial release
// ============================================================================
module ram_uart_dump_ctrl #(
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 8,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    output logic [ADDR_W-1:0] ram_rd_addr,
    input  logic [DATA_W-1:0] ram_q,
    output logic [DATA_W-1:0] uart_data,
    output logic              uart_trigger,
    input  logic              uart_busy,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   sent_count
);

    localparam int                 c_TMO_W    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(ACK_TIMEOUT - 1);
    localparam logic [ADDR_W:0]    c_ONE      = (ADDR_W + 1)'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_LATCH  = 3'd2,
        S_SEND   = 3'd3,
        S_DRAIN  = 3'd4,
        S_FINISH = 3'd5
    } state_t;

    state_t              r_state_q,   w_state_d;
    logic [ADDR_W-1:0]   r_ptr_q,     w_ptr_d;
    logic [ADDR_W:0]     r_rem_q,     w_rem_d;
    logic [ADDR_W-1:0]   r_rd_addr_q, w_rd_addr_d;
    logic [DATA_W-1:0]   r_data_q,    w_data_d;
    logic                r_trig_q,    w_trig_d;
    logic                r_busy_q,    w_busy_d;
    logic                r_done_q,    w_done_d;
    logic                r_error_q,   w_error_d;
    logic [ADDR_W:0]     r_sent_q,    w_sent_d;
    logic [c_TMO_W-1:0]  r_tmo_q,     w_tmo_d;

    always_comb begin
        w_state_d   = r_state_q;
        w_ptr_d     = r_ptr_q;
        w_rem_d     = r_rem_q;
        w_rd_addr_d = r_rd_addr_q;
        w_data_d    = r_data_q;
        w_trig_d    = r_trig_q;
        w_error_d   = r_error_q;
        w_sent_d    = r_sent_q;
        w_tmo_d     = r_tmo_q;

        case (r_state_q)
            S_IDLE: begin
                if (start) begin
                    w_ptr_d   = base_addr;
                    w_rem_d   = length;
                    w_sent_d  = '0;
                    w_error_d = 1'b0;
                    if (length == '0) begin
                        w_state_d = S_FINISH;
                    end else begin
                        w_rd_addr_d = base_addr;
                        w_state_d   = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                w_state_d = S_LATCH;
            end
            S_LATCH: begin
                // A UART still busy from outside traffic is waited out here.
                if (!uart_busy) begin
                    w_data_d  = ram_q;
                    w_trig_d  = 1'b1;
                    w_tmo_d   = '0;
                    w_state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (uart_busy) begin
                    w_trig_d  = 1'b0;
                    w_state_d = S_DRAIN;
                end else if (r_tmo_q == c_TMO_LAST) begin
                    // Trigger has now been high ACK_TIMEOUT cycles without an ack.
                    w_trig_d  = 1'b0;
                    w_error_d = 1'b1;
                    w_state_d = S_FINISH;
                end else begin
                    w_tmo_d = r_tmo_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (!uart_busy) begin
                    w_sent_d = r_sent_q + c_ONE;
                    if (r_rem_q > c_ONE) begin
                        w_ptr_d     = r_ptr_q + 1'b1;
                        w_rd_addr_d = r_ptr_q + 1'b1;
                        w_rem_d     = r_rem_q - c_ONE;
                        w_state_d   = S_FETCH;
                    end else begin
                        w_state_d = S_FINISH;
                    end
                end
            end
            S_FINISH: begin
                w_state_d = S_IDLE;
            end
            default: begin
                w_state_d = S_IDLE;
                w_trig_d  = 1'b0;
            end
        endcase

        // FINISH always lasts exactly one cycle, so done tracks it directly.
        w_done_d = (w_state_d == S_FINISH);
        w_busy_d = (w_state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q   <= S_IDLE;
            r_ptr_q     <= '0;
            r_rem_q     <= '0;
            r_rd_addr_q <= '0;
            r_data_q    <= '0;
            r_trig_q    <= 1'b0;
            r_busy_q    <= 1'b0;
            r_done_q    <= 1'b0;
            r_error_q   <= 1'b0;
            r_sent_q    <= '0;
            r_tmo_q     <= '0;
        end else begin
            r_state_q   <= w_state_d;
            r_ptr_q     <= w_ptr_d;
            r_rem_q     <= w_rem_d;
            r_rd_addr_q <= w_rd_addr_d;
            r_data_q    <= w_data_d;
            r_trig_q    <= w_trig_d;
            r_busy_q    <= w_busy_d;
            r_done_q    <= w_done_d;
            r_error_q   <= w_error_d;
            r_sent_q    <= w_sent_d;
            r_tmo_q     <= w_tmo_d;
        end
    end

    assign ram_rd_addr  = r_rd_addr_q;
    assign uart_data    = r_data_q;
    assign uart_trigger = r_trig_q;
    assign busy         = r_busy_q;
    assign done         = r_done_q;
    assign error        = r_error_q;
    assign sent_count   = r_sent_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_uart_dump_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_uart_dump_ctrl
// Brief    : Directed bench with a RAM model and a simple UART busy model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_uart_dump_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] base_addr;
    logic [4:0] length;
    logic [3:0] ram_rd_addr;
    logic [7:0] ram_q;
    logic [7:0] uart_data;
    logic       uart_trigger;
    logic       uart_busy;
    logic       busy;
    logic       done;
    logic       error;
    logic [4:0] sent_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ram_uart_dump_ctrl #(.ADDR_W(4), .DATA_W(8), .ACK_TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
        .ram_rd_addr(ram_rd_addr), .ram_q(ram_q), .uart_data(uart_data),
        .uart_trigger(uart_trigger), .uart_busy(uart_busy), .busy(busy), .done(done),
        .error(error), .sent_count(sent_count)
    );

    logic [7:0] ram [16];
    always @(posedge clk) ram_q <= ram[ram_rd_addr];

    // UART model: busy rises ack_dly cycles after a trigger and lasts frame_len cycles.
    int         frame_len = 100;
    int         ack_dly   = 2;
    logic       respond   = 1'b1;
    logic       ext_busy  = 1'b0;
    logic       m_busy    = 1'b0;
    int         m_phase   = 0;
    int         m_cnt     = 0;
    logic       trig_prev = 1'b0;
    int         rise_cnt  = 0;
    int         overlap_cnt = 0;
    logic [7:0] cap_q [$];

    assign uart_busy = m_busy | ext_busy;

    always @(posedge clk) begin
        trig_prev <= uart_trigger;
        if (uart_trigger && !trig_prev) begin
            rise_cnt <= rise_cnt + 1;
            cap_q.push_back(uart_data);
            if (uart_busy) overlap_cnt <= overlap_cnt + 1;
        end
        case (m_phase)
            0: if (uart_trigger && respond) begin m_phase <= 1; m_cnt <= 1; end
            1: if (m_cnt >= ack_dly) begin m_busy <= 1'b1; m_phase <= 2; m_cnt <= 1; end
               else m_cnt <= m_cnt + 1;
            default: if (m_cnt >= frame_len) begin m_busy <= 1'b0; m_phase <= 0; end
                     else m_cnt <= m_cnt + 1;
        endcase
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_start(input logic [3:0] b, input logic [4:0] l);
        base_addr = b;
        length    = l;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (done) begin ok = 1'b1; return; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; base_addr = '0; length = '0;
        for (int i = 0; i < 16; i++) ram[i] = 8'h00;
        tick(); tick();
        total++; if (ram_rd_addr !== 4'd0) begin bad++; $display("FAIL rst_addr got=%0d exp=0", ram_rd_addr); end
        total++; if (uart_data !== 8'h00) begin bad++; $display("FAIL rst_data got=%h exp=00", uart_data); end
        total++; if (uart_trigger !== 1'b0) begin bad++; $display("FAIL rst_trig got=%b exp=0", uart_trigger); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", done); end
        total++; if (error !== 1'b0) begin bad++; $display("FAIL rst_error got=%b exp=0", error); end
        total++; if (sent_count !== 5'd0) begin bad++; $display("FAIL rst_sent got=%0d exp=0", sent_count); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        bit ok;
        int r0 = rise_cnt;
        int c0 = cap_q.size();
        ram[0] = 8'hA5; frame_len = 100;
        do_start(4'd0, 5'd1);
        total++; if (busy !== 1'b1 || ram_rd_addr !== 4'd0) begin bad++; $display("FAIL single_fetch busy=%b addr=%0d exp busy=1 addr=0", busy, ram_rd_addr); end
        tick();
        total++; if (uart_trigger !== 1'b0) begin bad++; $display("FAIL single_latch_trig got=%b exp=0", uart_trigger); end
        tick();
        total++; if (uart_trigger !== 1'b1 || uart_data !== 8'hA5) begin bad++; $display("FAIL single_send trig=%b data=%h exp trig=1 data=a5", uart_trigger, uart_data); end
        wait_done(300, ok);
        total++; if (!ok) begin bad++; $display("FAIL single_done_timeout got=0 exp=1"); end
        total++; if (sent_count !== 5'd1 || error !== 1'b0) begin bad++; $display("FAIL single_result sent=%0d err=%b exp sent=1 err=0", sent_count, error); end
        total++; if (rise_cnt - r0 != 1 || cap_q[c0] !== 8'hA5) begin bad++; $display("FAIL single_uart triggers=%0d byte=%h exp 1 a5", rise_cnt - r0, cap_q[c0]); end
        tick();
        total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL single_after_done done=%b busy=%b exp 0 0", done, busy); end
    endtask

    task automatic test_burst_wrap();
        bit ok;
        logic [7:0] exp_b [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        int r0 = rise_cnt;
        int c0 = cap_q.size();
        int o0 = overlap_cnt;
        ram[14] = 8'h11; ram[15] = 8'h22; ram[0] = 8'h33; ram[1] = 8'h44;
        frame_len = 6;
        do_start(4'd14, 5'd4);
        wait_done(400, ok);
        total++; if (!ok) begin bad++; $display("FAIL burst_done_timeout got=0 exp=1"); end
        total++; if (rise_cnt - r0 != 4) begin bad++; $display("FAIL burst_triggers got=%0d exp=4", rise_cnt - r0); end
        for (int i = 0; i < 4; i++) begin
            total++; if (cap_q[c0 + i] !== exp_b[i]) begin bad++; $display("FAIL burst_byte%0d got=%h exp=%h", i, cap_q[c0 + i], exp_b[i]); end
        end
        total++; if (sent_count !== 5'd4 || error !== 1'b0) begin bad++; $display("FAIL burst_result sent=%0d err=%b exp 4 0", sent_count, error); end
        total++; if (overlap_cnt != o0) begin bad++; $display("FAIL burst_overlap got=%0d exp=0", overlap_cnt - o0); end
        tick();
    endtask

    task automatic test_zero_len();
        int r0 = rise_cnt;
        do_start(4'd5, 5'd0);
        total++; if (done !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL zero_done done=%b busy=%b exp 1 1", done, busy); end
        tick();
        total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL zero_after done=%b busy=%b exp 0 0", done, busy); end
        total++; if (sent_count !== 5'd0 || rise_cnt != r0) begin bad++; $display("FAIL zero_no_send sent=%0d triggers=%0d exp 0 0", sent_count, rise_cnt - r0); end
        total++; if (ram_rd_addr !== 4'd1) begin bad++; $display("FAIL zero_no_read addr=%0d exp=1", ram_rd_addr); end
    endtask

    task automatic test_ignored_start();
        bit ok;
        int r0 = rise_cnt;
        int c0 = cap_q.size();
        ram[3] = 8'h3C; ram[4] = 8'h4D;
        do_start(4'd3, 5'd2);
        for (int i = 0; i < 10; i++) tick();
        do_start(4'd9, 5'd7);
        wait_done(300, ok);
        total++; if (!ok) begin bad++; $display("FAIL ign_done_timeout got=0 exp=1"); end
        total++; if (sent_count !== 5'd2 || rise_cnt - r0 != 2) begin bad++; $display("FAIL ign_count sent=%0d triggers=%0d exp 2 2", sent_count, rise_cnt - r0); end
        total++; if (cap_q[c0] !== 8'h3C || cap_q[c0 + 1] !== 8'h4D) begin bad++; $display("FAIL ign_bytes got=%h %h exp=3c 4d", cap_q[c0], cap_q[c0 + 1]); end
        tick();
    endtask

    task automatic test_timeout();
        bit ok = 1'b0;
        int hi = 0;
        int r0 = rise_cnt;
        respond = 1'b0;
        do_start(4'd0, 5'd3);
        for (int i = 0; i < 60; i++) begin
            if (done) begin ok = 1'b1; break; end
            if (uart_trigger) hi++;
            tick();
        end
        total++; if (!ok) begin bad++; $display("FAIL tmo_done_missing got=0 exp=1"); end
        total++; if (hi != 15) begin bad++; $display("FAIL tmo_trig_cycles got=%0d exp=15", hi); end
        total++; if (error !== 1'b1 || sent_count !== 5'd0) begin bad++; $display("FAIL tmo_result err=%b sent=%0d exp 1 0", error, sent_count); end
        total++; if (rise_cnt - r0 != 1) begin bad++; $display("FAIL tmo_triggers got=%0d exp=1", rise_cnt - r0); end
        tick();
        total++; if (done !== 1'b0 || error !== 1'b1) begin bad++; $display("FAIL tmo_sticky done=%b err=%b exp 0 1", done, error); end
        respond = 1'b1;
        do_start(4'd0, 5'd1);
        total++; if (error !== 1'b0) begin bad++; $display("FAIL tmo_clear got=%b exp=0", error); end
        wait_done(300, ok);
        total++; if (!ok || sent_count !== 5'd1) begin bad++; $display("FAIL tmo_rerun ok=%b sent=%0d exp 1 1", ok, sent_count); end
        tick();
    endtask

    task automatic test_busy_at_start();
        bit ok;
        int r0 = rise_cnt;
        int c0 = cap_q.size();
        ram[2] = 8'h5C;
        ext_busy = 1'b1;
        for (int i = 0; i < 50; i++) tick();
        do_start(4'd2, 5'd1);
        for (int i = 0; i < 10; i++) tick();
        total++; if (uart_trigger !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL bas_wait trig=%b busy=%b exp 0 1", uart_trigger, busy); end
        total++; if (ram_rd_addr !== 4'd2) begin bad++; $display("FAIL bas_addr got=%0d exp=2", ram_rd_addr); end
        ext_busy = 1'b0;
        wait_done(300, ok);
        total++; if (!ok || sent_count !== 5'd1) begin bad++; $display("FAIL bas_done ok=%b sent=%0d exp 1 1", ok, sent_count); end
        total++; if (rise_cnt - r0 != 1 || cap_q[c0] !== 8'h5C) begin bad++; $display("FAIL bas_byte triggers=%0d byte=%h exp 1 5c", rise_cnt - r0, cap_q[c0]); end
        tick();
    endtask

    task automatic test_reset_mid();
        bit ok = 1'b0;
        bit done_seen = 1'b0;
        int r0 = rise_cnt;
        int r1;
        int c1;
        for (int i = 4; i < 9; i++) ram[i] = 8'(8'h60 + i);
        ram[0] = 8'hA5; ram[1] = 8'h44;
        frame_len = 8;
        do_start(4'd4, 5'd5);
        for (int i = 0; i < 200; i++) begin
            if (rise_cnt - r0 == 2 && uart_busy && !uart_trigger && busy) begin ok = 1'b1; break; end
            tick();
        end
        total++; if (!ok) begin bad++; $display("FAIL rmid_reach_drain got=0 exp=1"); end
        #2 rst = 1'b1;
        #1;
        total++; if (busy !== 1'b0 || uart_trigger !== 1'b0 || sent_count !== 5'd0) begin bad++; $display("FAIL rmid_async busy=%b trig=%b sent=%0d exp 0 0 0", busy, uart_trigger, sent_count); end
        total++; if (ram_rd_addr !== 4'd0 || uart_data !== 8'h00 || error !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL rmid_async2 addr=%0d data=%h err=%b done=%b exp 0 00 0 0", ram_rd_addr, uart_data, error, done); end
        for (int i = 0; i < 25; i++) begin
            tick();
            if (i == 4) rst = 1'b0;
            if (done) done_seen = 1'b1;
        end
        total++; if (done_seen) begin bad++; $display("FAIL rmid_no_done got=1 exp=0"); end
        for (int i = 0; i < 50 && uart_busy; i++) tick();
        r1 = rise_cnt;
        c1 = cap_q.size();
        do_start(4'd0, 5'd2);
        wait_done(300, ok);
        total++; if (!ok || sent_count !== 5'd2 || rise_cnt - r1 != 2) begin bad++; $display("FAIL rmid_rerun ok=%b sent=%0d triggers=%0d exp 1 2 2", ok, sent_count, rise_cnt - r1); end
        total++; if (cap_q[c1] !== 8'hA5 || cap_q[c1 + 1] !== 8'h44) begin bad++; $display("FAIL rmid_bytes got=%h %h exp=a5 44", cap_q[c1], cap_q[c1 + 1]); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst_wrap();
        test_zero_len();
        test_ignored_start();
        test_timeout();
        test_busy_at_start();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
`default_nettype wire
